global_mem_responder: RTL and testbench

//  Memory-side responder for the mem_controller channel interface: NUM_CHANNELS independent channels sharing one

---
 rtl/global_mem_responder.sv | 115 +++++++++++
 tb/tb_global_mem_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/global_mem_responder.sv
// Multi-channel global memory responder: shared word-addressed storage, fixed-latency
// single-cycle response pulse per channel, and a host preload port.
module global_mem_responder #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned BYTE_LANES   = 4,
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned LATENCY      = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   output logic [NUM_CHANNELS-1:0]              mem_ready,
   input  logic [NUM_CHANNELS-1:0]              mem_valid,
   input  logic [NUM_CHANNELS*BYTE_LANES-1:0]   mem_we,
   input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   mem_addr,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_data,
   output logic [NUM_CHANNELS-1:0]              mem_resp_valid,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   mem_resp_data,
   input  logic                                 load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0]       load_addr,
   input  logic [DATA_WIDTH-1:0]                load_data
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                 state_q     [NUM_CHANNELS];
   state_t                 state_d     [NUM_CHANNELS];
   logic [CNT_W-1:0]       cnt_q       [NUM_CHANNELS];
   logic [CNT_W-1:0]       cnt_d       [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]  snap_q      [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]  resp_data_q [NUM_CHANNELS];
   logic [IDX_W-1:0]       idx         [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] accept;
   logic [NUM_CHANNELS-1:0] is_write;
   logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];
   logic                   unused_addr;

   assign unused_addr = ^mem_addr;

   // Unknown byte enables on an accepted request fall back to a read.
   always_comb begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         idx[c]       = mem_addr[c*ADDR_WIDTH +: IDX_W];
         accept[c]    = mem_valid[c] && (state_q[c] == IDLE) && !reset;
         is_write[c]  = accept[c] && !$isunknown(mem_we[c*BYTE_LANES +: BYTE_LANES])
                        && (|mem_we[c*BYTE_LANES +: BYTE_LANES]);
         mem_ready[c]      = (state_q[c] == IDLE);
         mem_resp_valid[c] = (state_q[c] == RESP);
         mem_resp_data[c*DATA_WIDTH +: DATA_WIDTH] = resp_data_q[c];
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         unique case (state_q[c])
            IDLE: begin
               if (accept[c]) begin
                  cnt_d[c]   = CNT_LOAD;
                  state_d[c] = (LATENCY == 1) ? RESP : BUSY;
               end
            end
            BUSY: begin
               cnt_d[c] = cnt_q[c] - CNT_W'(1);
               if (cnt_q[c] == CNT_W'(1)) state_d[c] = RESP;
            end
            RESP:    state_d[c] = IDLE;
            default: state_d[c] = IDLE;
         endcase
      end
   end

   // With LATENCY==1 the response is loaded straight from storage at the accept edge.
   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (reset) begin
            state_q[c]     <= IDLE;
            cnt_q[c]       <= '0;
            snap_q[c]      <= '0;
            resp_data_q[c] <= '0;
         end else begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
            if (accept[c]) snap_q[c] <= mem[idx[c]];
            if (state_d[c] == RESP && state_q[c] != RESP)
               resp_data_q[c] <= (state_q[c] == IDLE) ? mem[idx[c]] : snap_q[c];
         end
      end
   end

   // Later writes in this block win per byte: load port, then channels in index order.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_addr] <= load_data;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         for (int unsigned b = 0; b < BYTE_LANES; b++) begin
            if (is_write[c] && mem_we[c*BYTE_LANES + b])
               mem[idx[c]][b*8 +: 8] <= mem_data[c*DATA_WIDTH + b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (!reset && mem_valid[c] && state_q[c] == IDLE)
            assert (!$isunknown(mem_we[c*BYTE_LANES +: BYTE_LANES]));
      end
   end

endmodule

// File: tb/tb_global_mem_responder.sv
// Directed bench for global_mem_responder: default instance (LATENCY=4) and a
// LATENCY=1 single-channel instance for the short-latency wrap case.
module tb_global_mem_responder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0]   mem_ready, mem_valid, mem_resp_valid;
   logic [15:0]  mem_we;
   logic [127:0] mem_addr, mem_data, mem_resp_data;
   logic         load_en;
   logic [9:0]   load_addr;
   logic [31:0]  load_data;

   logic         s_ready, s_valid, s_resp_valid;
   logic [3:0]   s_we;
   logic [31:0]  s_addr, s_data, s_resp_data;
   logic         s_load_en;
   logic [3:0]   s_load_addr;
   logic [31:0]  s_load_data;

   int n_cmp = 0;
   int n_err = 0;

   global_mem_responder dut (
      .clk(clk), .reset(reset), .mem_ready(mem_ready), .mem_valid(mem_valid),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
   );

   global_mem_responder #(.NUM_CHANNELS(1), .DEPTH_WORDS(16), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .mem_ready(s_ready), .mem_valid(s_valid),
      .mem_we(s_we), .mem_addr(s_addr), .mem_data(s_data),
      .mem_resp_valid(s_resp_valid), .mem_resp_data(s_resp_data),
      .load_en(s_load_en), .load_addr(s_load_addr), .load_data(s_load_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic set_req(input int ch, input logic [3:0] we, input logic [31:0] a,
                          input logic [31:0] d);
      mem_valid[ch]      = 1'b1;
      mem_we[ch*4 +: 4]  = we;
      mem_addr[ch*32 +: 32] = a;
      mem_data[ch*32 +: 32] = d;
   endtask

   // Accept edge, three BUSY samples, RESP sample, then the IDLE sample with held data.
   task automatic txn(input int ch, input logic [3:0] we, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input string tag);
      set_req(ch, we, a, d);
      step();
      mem_valid[ch] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_busy%0d", tag, i), 32'({mem_ready[ch], mem_resp_valid[ch]}), 32'h0);
         step();
      end
      check({tag, "_pulse"}, 32'({mem_ready[ch], mem_resp_valid[ch]}), 32'h1);
      check({tag, "_data"}, mem_resp_data[ch*32 +: 32], exp);
      step();
      check({tag, "_idle"}, 32'({mem_ready[ch], mem_resp_valid[ch]}), 32'h2);
      check({tag, "_hold"}, mem_resp_data[ch*32 +: 32], exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      mem_valid = '0; mem_we = '0; mem_addr = '0; mem_data = '0;
      load_en = 1'b0; load_addr = '0; load_data = '0;
      s_valid = 1'b0; s_we = '0; s_addr = '0; s_data = '0;
      s_load_en = 1'b0; s_load_addr = '0; s_load_data = '0;
      step(); step();
      check("rst_ready", 32'(mem_ready), 32'hF);
      check("rst_rvalid", 32'(mem_resp_valid), 32'h0);
      check("rst_rdata_or", 32'(|mem_resp_data), 32'h0);
      reset = 1'b0;
      step();
      check("post_rst_ready", 32'(mem_ready), 32'hF);
      check("post_rst_ready_l1", 32'(s_ready), 32'h1);

      // Test 1: preload and read back.
      preload(10'd5, 32'hDEADBEEF);
      txn(0, 4'b0000, 32'd5, 32'h0, 32'hDEADBEEF, "t1");

      // Test 2: byte-masked write returns old word; read shows merge.
      preload(10'd7, 32'hAAAAAAAA);
      txn(1, 4'b0101, 32'd7, 32'h11223344, 32'hAAAAAAAA, "t2w");
      txn(1, 4'b0000, 32'd7, 32'h0, 32'hAA22AA44, "t2r");

      // Test 3: same-edge writers and reader on one word.
      preload(10'd3, 32'h0);
      set_req(0, 4'b1111, 32'd3, 32'h0000FFFF);
      set_req(2, 4'b0011, 32'd3, 32'h12345678);
      set_req(3, 4'b0000, 32'd3, 32'h0);
      step();
      mem_valid = '0;
      step(); step(); step();
      check("t3_pulse", 32'(mem_resp_valid), 32'hD);
      check("t3_ch0_old", mem_resp_data[31:0], 32'h0);
      check("t3_ch2_old", mem_resp_data[95:64], 32'h0);
      check("t3_ch3_read", mem_resp_data[127:96], 32'h0);
      step();
      txn(1, 4'b0000, 32'd3, 32'h0, 32'h00005678, "t3r");

      // Test 4: all channels hold back-to-back reads.
      for (int c = 0; c < 4; c++) preload(10'(20 + c), 32'hC0DE0000 + 32'(c));
      for (int c = 0; c < 4; c++) set_req(c, 4'b0000, 32'(20 + c), 32'h0);
      for (int i = 0; i < 15; i++) begin
         step();
         check($sformatf("t4_rvalid%0d", i), 32'(mem_resp_valid), (i % 5 == 3) ? 32'hF : 32'h0);
         check($sformatf("t4_ready%0d", i), 32'(mem_ready), (i % 5 == 4) ? 32'hF : 32'h0);
         if (i % 5 == 3)
            for (int c = 0; c < 4; c++)
               check($sformatf("t4_data%0d_ch%0d", i, c), mem_resp_data[c*32 +: 32],
                     32'hC0DE0000 + 32'(c));
      end
      mem_valid = '0;

      // Address wrap on the default instance.
      txn(2, 4'b0000, 32'd1029, 32'h0, 32'hDEADBEEF, "wrap");

      // Test 5: reset two cycles after accept drops the request.
      set_req(0, 4'b0000, 32'd5, 32'h0);
      step();
      mem_valid = '0;
      check("t5_busy0", 32'(mem_ready[0]), 32'h0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_ready", 32'(mem_ready), 32'hF);
      check("t5_rdata_clr", mem_resp_data[31:0], 32'h0);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("t5_nopulse%0d", i), 32'(mem_resp_valid), 32'h0);
      end
      txn(0, 4'b0000, 32'd5, 32'h0, 32'hDEADBEEF, "t5mem");

      // Test 6: LATENCY=1 instance, wrapped address.
      s_load_en = 1'b1; s_load_addr = 4'd5; s_load_data = 32'hCAFEF00D;
      step();
      s_load_en = 1'b0;
      check("t6_ready0", 32'(s_ready), 32'h1);
      s_valid = 1'b1; s_we = 4'b0000; s_addr = 32'd21;
      step();
      s_valid = 1'b0;
      check("t6_pulse", 32'({s_ready, s_resp_valid}), 32'h1);
      check("t6_data", s_resp_data, 32'hCAFEF00D);
      step();
      check("t6_idle", 32'({s_ready, s_resp_valid}), 32'h2);
      check("t6_hold", s_resp_data, 32'hCAFEF00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
